// File: rtl/memory_access_if.sv
// Bundle between the pipeline memory stage and its neighbours: execute operands in, data-memory req/ready bus, writeback out.
// Latency: none, wires only.
// Backpressure: stall and mem_req/mem_ready carry the flow control; this interface itself adds none.
//
// Ports (master = memory stage, slave = surrounding pipeline / memory):
//   control_in, result_in, store_data, dest_in, wr_en_in : execute outputs into the stage
//   stall                                                  : upstream hold while a transaction is outstanding
//   mem_req, mem_we, mem_addr, mem_wdata                   : data-memory request side
//   mem_ready, mem_rdata                                   : data-memory response side
//   wb_data, wb_dest, wb_en                                : registered writeback bundle
//   mem_err                                                : timeout-abort pulse
interface memory_access_if;
   logic [3:0]  control_in;
   logic [15:0] result_in;
   logic [15:0] store_data;
   logic [4:0]  dest_in;
   logic        wr_en_in;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] wb_data;
   logic [4:0]  wb_dest;
   logic        wb_en;
   logic        mem_err;

   modport master (
      input  control_in, result_in, store_data, dest_in, wr_en_in,
      input  mem_ready, mem_rdata,
      output stall, mem_req, mem_we, mem_addr, mem_wdata,
      output wb_data, wb_dest, wb_en, mem_err
   );

   modport slave (
      output control_in, result_in, store_data, dest_in, wr_en_in,
      output mem_ready, mem_rdata,
      input  stall, mem_req, mem_we, mem_addr, mem_wdata,
      input  wb_data, wb_dest, wb_en, mem_err
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage: retires ALU ops directly, turns LOAD/STORE into a req/ready data-memory transaction with timeout abort.
// Latency: 1 cycle for non-memory ops; loads retire one edge after the mem_ready cycle (2 cycles minimum).
// Backpressure: stall is held while a transaction is outstanding; inputs are only sampled when not stalled.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : memory_access_if.master -- execute operands, data-memory bus, writeback bundle, mem_err
module memory_access #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [3:0]  OP_LOAD  = 4'b1100,
   parameter logic [3:0]  OP_STORE = 4'b1110
) (
   input  logic            clk,
   input  logic            rst,
   memory_access_if.master bus
);

   // Counter is cleared on every BUSY entry and stops at TIMEOUT-1, so it never wraps.
   localparam int unsigned    CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    dest_q, dest_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [15:0]   mem_addr_q, mem_addr_d;
   logic [15:0]   mem_wdata_q, mem_wdata_d;
   logic [15:0]   wb_data_q, wb_data_d;
   logic [4:0]    wb_dest_q, wb_dest_d;
   logic          wb_en_q, wb_en_d;
   logic          mem_err_q, mem_err_d;

   logic is_mem_op;
   logic timeout_hit;

   assign is_mem_op   = (bus.control_in == OP_LOAD) || (bus.control_in == OP_STORE);
   assign timeout_hit = (cnt_q == CNT_LAST);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dest_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wb_data_q   <= '0;
         wb_dest_q   <= '0;
         wb_en_q     <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dest_q      <= dest_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wb_data_q   <= wb_data_d;
         wb_dest_q   <= wb_dest_d;
         wb_en_q     <= wb_en_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Next-state logic. mem_ready takes priority over an expiring timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (is_mem_op) state_d = BUSY;
         end
         BUSY: begin
            if (bus.mem_ready || timeout_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      cnt_d       = cnt_q;
      dest_d      = dest_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_data_d   = wb_data_q;
      wb_dest_d   = wb_dest_q;
      wb_en_d     = 1'b0;
      mem_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_mem_op) begin
               mem_req_d   = 1'b1;
               mem_we_d    = (bus.control_in == OP_STORE);
               mem_addr_d  = bus.result_in;
               mem_wdata_d = bus.store_data;
               dest_d      = bus.dest_in;
               cnt_d       = '0;
            end else begin
               wb_data_d = bus.result_in;
               wb_dest_d = bus.dest_in;
               wb_en_d   = bus.wr_en_in;
            end
         end
         BUSY: begin
            if (bus.mem_ready) begin
               // mem_we_q doubles as the latched load/store kind for the whole transaction.
               if (!mem_we_q) begin
                  wb_en_d   = 1'b1;
                  wb_data_d = bus.mem_rdata;
                  wb_dest_d = dest_q;
               end
            end else if (timeout_hit) begin
               mem_err_d = 1'b1;
            end else begin
               mem_req_d = 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
         end
      endcase
   end

   assign bus.stall     = (state_q == BUSY);
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_dest   = wb_dest_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.mem_err   = mem_err_q;

endmodule
